// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage of the 5-stage MIPS pipeline plus the MEM/WB boundary register.
// Performs the data-memory access, selects the writeback value and registers it for the
// register-file write port. Synchronous active-high reset; memory contents survive reset.
// Optional feature: define MEM_ALIGN_CHK_EN to add the sticky misalign output and to
// suppress misaligned stores / loads' register writes.

module mem_wb_stage #(
   parameter int unsigned DMEM_WORDS = 1024,
   parameter int unsigned ADDR_W     = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ddpc4,
   input  logic [31:0] dbusw,
   input  logic [31:0] ddata2,
   input  logic [4:0]  drw,
   input  logic        nnreg_write,
   input  logic        nnmem_write,
   input  logic [1:0]  nns_data_write,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rw,
   output logic        wb_reg_write,
   output logic [31:0] mem_rdata,
`ifdef MEM_ALIGN_CHK_EN
   output logic        misalign,
`endif
   output logic [15:0] store_cnt
);

   logic [31:0]       dmem [DMEM_WORDS];
   logic [ADDR_W-1:0] word_idx;
   logic              access_bad;
   logic              store_en;
   logic              reg_write_d;
   logic [31:0]       wb_data_d;

   // Upper address bits alias; byte-offset bits only matter to the alignment check.
   assign word_idx = dbusw[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHK_EN
   assign access_bad = (dbusw[1:0] != 2'b00) &&
                       (nnmem_write || (nns_data_write == 2'b01));
   logic unused_addr;
   assign unused_addr = ^dbusw[31:ADDR_W+2];
`else
   assign access_bad = 1'b0;
   logic unused_addr;
   assign unused_addr = ^{dbusw[31:ADDR_W+2], dbusw[1:0]};
`endif

   assign store_en    = nnmem_write && !access_bad;
   assign reg_write_d = nnreg_write && !access_bad;

   // Asynchronous read gives read-before-write for a same-cycle load and store.
   assign mem_rdata = dmem[word_idx];

   // Writeback source select ahead of the MEM/WB register.
   always_comb begin
      wb_data_d = 32'h0;
      unique case (nns_data_write)
         2'b00:   wb_data_d = dbusw;
         2'b01:   wb_data_d = mem_rdata;
         2'b10:   wb_data_d = ddpc4;
         default: wb_data_d = 32'h0;
      endcase
   end

   // Data memory write port; a store presented during reset is dropped.
   always_ff @(posedge clock) begin
      if (!reset && store_en) begin
         dmem[word_idx] <= ddata2;
      end
   end

   // MEM/WB boundary register, loaded every non-reset edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_data      <= 32'h0;
         wb_rw        <= 5'd0;
         wb_reg_write <= 1'b0;
      end else begin
         wb_data      <= wb_data_d;
         wb_rw        <= drw;
         wb_reg_write <= reg_write_d;
      end
   end

   // Committed-store counter, wraps modulo 2^16.
   always_ff @(posedge clock) begin
      if (reset) begin
         store_cnt <= 16'h0;
      end else if (store_en) begin
         store_cnt <= store_cnt + 16'd1;
      end
   end

`ifdef MEM_ALIGN_CHK_EN
   // Sticky misaligned-access flag, cleared only by reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         misalign <= 1'b0;
      end else if (access_bad) begin
         misalign <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.

module tb_mem_wb_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] ddpc4;
   logic [31:0] dbusw;
   logic [31:0] ddata2;
   logic [4:0]  drw;
   logic        nnreg_write;
   logic        nnmem_write;
   logic [1:0]  nns_data_write;
   logic [31:0] wb_data;
   logic [4:0]  wb_rw;
   logic        wb_reg_write;
   logic [31:0] mem_rdata;
   logic [15:0] store_cnt;
`ifdef MEM_ALIGN_CHK_EN
   logic        misalign;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_wb_stage #(
      .DMEM_WORDS (1024),
      .ADDR_W     (10)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ddpc4          (ddpc4),
      .dbusw          (dbusw),
      .ddata2         (ddata2),
      .drw            (drw),
      .nnreg_write    (nnreg_write),
      .nnmem_write    (nnmem_write),
      .nns_data_write (nns_data_write),
      .wb_data        (wb_data),
      .wb_rw          (wb_rw),
      .wb_reg_write   (wb_reg_write),
      .mem_rdata      (mem_rdata),
`ifdef MEM_ALIGN_CHK_EN
      .misalign       (misalign),
`endif
      .store_cnt      (store_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rw,
                        input logic rwe, input logic mwe, input logic [1:0] sel);
      dbusw          = addr;
      ddata2         = wdata;
      drw            = rw;
      nnreg_write    = rwe;
      nnmem_write    = mwe;
      nns_data_write = sel;
   endtask

   initial begin
      reset = 1'b1;
      ddpc4 = 32'h0;
      drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
      #1;

      // Reset held for two edges.
      tick();
      tick();
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_wb_rw", {27'h0, wb_rw}, 32'h0);
      check("rst_wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
      check("rst_store_cnt", {16'h0, store_cnt}, 32'h0);

      // Store 0xDEADBEEF to 0x40 (ALU result passes to wb_data).
      reset = 1'b0;
      drive(32'h40, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 2'b00);
      tick();
      check("st_cnt1", {16'h0, store_cnt}, 32'd1);
      check("st_wb_data_alu", wb_data, 32'h40);
      check("st_wb_reg_write", {31'h0, wb_reg_write}, 32'h0);

      // Load 0x40 into r8.
      drive(32'h40, 32'h0, 5'd8, 1'b1, 1'b0, 2'b01);
      #1;
      check("ld_mem_rdata", mem_rdata, 32'hDEADBEEF);
      tick();
      check("ld_wb_data", wb_data, 32'hDEADBEEF);
      check("ld_wb_rw", {27'h0, wb_rw}, 32'd8);
      check("ld_wb_reg_write", {31'h0, wb_reg_write}, 32'h1);
      check("ld_cnt", {16'h0, store_cnt}, 32'd1);

      // Writeback mux selects.
      ddpc4 = 32'h0040_0008;
      drive(32'h1234, 32'h0, 5'd31, 1'b1, 1'b0, 2'b00);
      tick();
      check("mux_00", wb_data, 32'h1234);
      check("mux_rw", {27'h0, wb_rw}, 32'd31);
      nns_data_write = 2'b10;
      tick();
      check("mux_10", wb_data, 32'h0040_0008);
      nns_data_write = 2'b11;
      tick();
      check("mux_11", wb_data, 32'h0);

      // Aliasing: 0x1010 maps to the same word as 0x10.
      drive(32'h10, 32'hA5A5A5A5, 5'd3, 1'b0, 1'b1, 2'b00);
      tick();
      drive(32'h1010, 32'h0, 5'd3, 1'b1, 1'b0, 2'b01);
      tick();
      check("alias_wb_data", wb_data, 32'hA5A5A5A5);
      check("alias_cnt", {16'h0, store_cnt}, 32'd2);

      // Same-cycle load and store of one word returns old data.
      drive(32'h20, 32'h11111111, 5'd4, 1'b0, 1'b1, 2'b00);
      tick();
      drive(32'h20, 32'h22222222, 5'd4, 1'b1, 1'b1, 2'b01);
      tick();
      check("rbw_old", wb_data, 32'h11111111);
      check("rbw_cnt", {16'h0, store_cnt}, 32'd4);
      drive(32'h20, 32'h0, 5'd4, 1'b1, 1'b0, 2'b01);
      tick();
      check("rbw_new", wb_data, 32'h22222222);

      // Store suppressed while reset is high.
      drive(32'h80, 32'h12345678, 5'd5, 1'b0, 1'b1, 2'b00);
      tick();
      check("pre_rst_cnt", {16'h0, store_cnt}, 32'd5);
      reset = 1'b1;
      drive(32'h80, 32'h55, 5'd5, 1'b1, 1'b1, 2'b00);
      tick();
      check("rst_st_cnt", {16'h0, store_cnt}, 32'd0);
      check("rst_st_wb_data", wb_data, 32'h0);
      check("rst_st_wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
      reset = 1'b0;
      drive(32'h80, 32'h0, 5'd5, 1'b1, 1'b0, 2'b01);
      tick();
      check("rst_st_mem_kept", wb_data, 32'h12345678);
      check("rst_st_cnt_after", {16'h0, store_cnt}, 32'd0);

      // r0 write enable passes through unchanged.
      drive(32'h7, 32'h0, 5'd0, 1'b1, 1'b0, 2'b00);
      tick();
      check("r0_reg_write", {31'h0, wb_reg_write}, 32'h1);
      check("r0_wb_rw", {27'h0, wb_rw}, 32'd0);
      check("r0_wb_data", wb_data, 32'h7);

`ifdef MEM_ALIGN_CHK_EN
      check("mis_init", {31'h0, misalign}, 32'h0);
      // Misaligned store to 0x42 is dropped.
      drive(32'h42, 32'h99999999, 5'd6, 1'b0, 1'b1, 2'b00);
      tick();
      check("mis_flag", {31'h0, misalign}, 32'h1);
      check("mis_cnt", {16'h0, store_cnt}, 32'd0);
      drive(32'h40, 32'h0, 5'd6, 1'b1, 1'b0, 2'b01);
      tick();
      check("mis_old_data", wb_data, 32'hDEADBEEF);
      // Misaligned load loses its register write.
      drive(32'h41, 32'h0, 5'd6, 1'b1, 1'b0, 2'b01);
      tick();
      check("mis_ld_reg_write", {31'h0, wb_reg_write}, 32'h0);
      check("mis_sticky", {31'h0, misalign}, 32'h1);
`else
      // Byte offset ignored: 0x83 reads the word at 0x80, 0x42 stores into 0x40.
      drive(32'h83, 32'h0, 5'd6, 1'b1, 1'b0, 2'b01);
      tick();
      check("unal_ld", wb_data, 32'h12345678);
      check("unal_ld_reg_write", {31'h0, wb_reg_write}, 32'h1);
      drive(32'h42, 32'h99999999, 5'd6, 1'b0, 1'b1, 2'b00);
      tick();
      check("unal_st_cnt", {16'h0, store_cnt}, 32'd1);
      drive(32'h40, 32'h0, 5'd6, 1'b1, 1'b0, 2'b01);
      tick();
      check("unal_st_data", wb_data, 32'h99999999);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline interface in the 5-stage MIPS pipeline (no hazard handling).
- Takes the registered EX/MEM bundle: PC+4, ALU result/address, store data, destination register, reg-write, mem-write and 2-bit writeback select.
- Performs the data-memory access and selects the writeback value.
- Registers the result into the MEM/WB boundary, which drives the register-file write port.

Parameters:
- DMEM_WORDS, 1024, data memory depth in 32-bit words (power of two).
- ADDR_W, 10, word-address width; must equal log2(DMEM_WORDS).

Ports:
- clock  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- ddpc4  in  32  PC+4 of the instruction in MEM
- dbusw  in  32  ALU result; byte address for load/store
- ddata2  in  32  store data (rt value)
- drw  in  5  destination register number
- nnreg_write  in  1  instruction writes the register file
- nnmem_write  in  1  instruction stores a word
- nns_data_write  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 zero
- wb_data  out  32  registered writeback value
- wb_rw  out  5  registered destination register
- wb_reg_write  out  1  registered register-file write enable
- mem_rdata  out  32  combinational memory read data at dbusw (debug/visibility)
- store_cnt  out  16  count of committed stores, wraps at 0xFFFF->0

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high; polarity and synchronicity are fixed.
  - On a clock edge with reset=1: wb_data=0, wb_rw=0, wb_reg_write=0, store_cnt=0. Any store presented in that cycle is suppressed.
  - Memory contents are not cleared by reset.
- Word index: dbusw[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias modulo DMEM_WORDS*4.
- Read path:
  - Combinational read; mem_rdata = dmem[index] every cycle.
  - Same-cycle load and store to the same word returns the OLD contents (read-before-write).
- Store: when nnmem_write=1 and reset=0, dmem[index] <= ddata2 at the edge, and store_cnt increments by 1 modulo 2^16.
- Writeback mux (combinational, before the MEM/WB register):
  - 00 -> dbusw
  - 01 -> mem_rdata
  - 10 -> ddpc4
  - 11 -> 32'h0
- MEM/WB register:
  - Latency 1 cycle: inputs at edge N appear on wb_* after edge N.
  - Loads wb_data, wb_rw and wb_reg_write = nnreg_write every non-reset edge; no stall or flush.
- Writes to register 0: wb_reg_write is passed through unchanged; the register file ignores writes to r0.
- Back-to-back store then load of the same word in consecutive cycles: the load sees the new data, because the store committed at the earlier edge.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - Adds output port misalign (1 bit, sticky, reset to 0).
  - If dbusw[1:0] != 0 and either nnmem_write=1 or nns_data_write=01, the store is suppressed, store_cnt does not increment, and wb_reg_write is forced to 0 for that instruction.
  - misalign sets to 1 and holds until reset.
- Undefined:
  - No misalign port.
  - dbusw[1:0] is ignored; accesses act on the word containing the address.

Test Plan:
- Reset then idle: assert reset 2 cycles -> wb_data=0, wb_rw=0, wb_reg_write=0, store_cnt=0.
- Store then load: cycle 1 store 0xDEADBEEF to 0x40; cycle 2 load 0x40 with rw=8, reg_write=1, sel=01 -> after edge 2: wb_data=0xDEADBEEF, wb_rw=8, wb_reg_write=1, store_cnt=1.
- Mux select: dbusw=0x1234, ddpc4=0x0040_0008, rw=31. sel=00 -> wb_data=0x1234; sel=10 -> 0x0040_0008; sel=11 -> 0.
- Aliasing: store 0xA5A5A5A5 to 0x0000_0010, then load from 0x0000_1010 (DMEM_WORDS=1024) -> wb_data=0xA5A5A5A5.
- Reset mid-store: nnmem_write=1, ddata2=0x55 to 0x80 with reset=1; then load 0x80 -> prior contents unchanged, store_cnt=0.
- With MEM_ALIGN_CHK_EN: store to 0x42 then load 0x40 -> old data returned, misalign=1, store_cnt unchanged, wb_reg_write=0 for the misaligned op.
